decoder_2to4: RTL and testbench

//   Registered binary-to-one-hot decoder: 2-bit code in, 4-bit one-hot code out.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_onehot_comb.sv | 23 ++
 rtl/decoder_2to4.sv | 65 ++++++
 tb/tb_decoder_2to4.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the binary-to-one-hot decoder family.
package decoder_pkg;

  // Default code width; 2 gives the 2-to-4 decoder.
  localparam int unsigned DEC_N_DEFAULT = 2;

  // Per-line value for reset and disabled decode. Replicate it to the output width.
  localparam logic DEC_ZERO = 1'b0;

  // Output width of an n-bit code decoder.
  function automatic int unsigned DEC_OUT_W(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/decoder_onehot_comb.sv
// Combinational enable-gated binary-to-one-hot decode.
// Built as a loop so it scales with N. X on en/in propagates to the output.
module decoder_onehot_comb
  import decoder_pkg::*;
#(
  parameter int unsigned N = DEC_N_DEFAULT
) (
  input  logic                    en,
  input  logic [N-1:0]            in,
  output logic [DEC_OUT_W(N)-1:0] onehot
);

  localparam int unsigned OutW = DEC_OUT_W(N);

  // Each line is asserted when enabled and the code matches its index.
  always_comb begin
    onehot = {OutW{DEC_ZERO}};
    for (int unsigned i = 0; i < OutW; i++) begin
      onehot[i] = en & (in == N'(i));
    end
  end

endmodule

// File: rtl/decoder_2to4.sv
// Registered binary-to-one-hot decoder with a one-cycle latency and synchronous reset.
// Optional feature: define DECODER_2TO4_VALID_EN to add a 'valid' output, which is a
// registered copy of en aligned with bcode.
module decoder_2to4
  import decoder_pkg::*;
#(
  parameter int unsigned N = DEC_N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [N-1:0]            in,
  output logic [DEC_OUT_W(N)-1:0] bcode
`ifdef DECODER_2TO4_VALID_EN
  ,
  output logic                    valid
`endif
);

  localparam int unsigned OutW = DEC_OUT_W(N);

  logic [OutW-1:0] bcode_d;
  logic [OutW-1:0] bcode_q;

  decoder_onehot_comb #(
    .N(N)
  ) u_onehot (
    .en    (en),
    .in    (in),
    .onehot(bcode_d)
  );

  // Output register; reset wins over any decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcode_q <= {OutW{DEC_ZERO}};
    end else begin
      bcode_q <= bcode_d;
    end
  end

  assign bcode = bcode_q;

`ifdef DECODER_2TO4_VALID_EN
  logic valid_q;

  // valid tracks en with the same latency as bcode.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= DEC_ZERO;
    end else begin
      valid_q <= en;
    end
  end

  assign valid = valid_q;

  valid_onehot_a: assert property (@(posedge clk) disable iff (reset)
    valid_q |-> $onehot(bcode_q));
`endif

  // The registered output must never have more than one line set.
  onehot0_a: assert property (@(posedge clk) disable iff (reset) $onehot0(bcode_q));

endmodule

// File: tb/tb_decoder_2to4.sv
// Self-checking bench for decoder_2to4: directed vector table, hand-written
// reset/toggle/hold sequences, and a random run against a small reference model.
module tb_decoder_2to4;
  import decoder_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] in;
  logic [3:0] bcode;
`ifdef DECODER_2TO4_VALID_EN
  logic       valid;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_2to4 #(
    .N(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .in   (in),
    .bcode(bcode)
`ifdef DECODER_2TO4_VALID_EN
    ,
    .valid(valid)
`endif
  );

  typedef struct {
    string      name;
    logic       reset;
    logic       en;
    logic [1:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic r, input logic e,
                              input logic [1:0] c, input logic [3:0] exp);
    vec_t v;
    v.name  = name;
    v.reset = r;
    v.en    = e;
    v.in    = c;
    v.exp   = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] exp_code, input logic exp_valid);
    checks++;
    if (bcode !== exp_code) begin
      failures++;
      $display("FAIL %s: bcode=%b expected=%b", name, bcode, exp_code);
    end
`ifdef DECODER_2TO4_VALID_EN
    checks++;
    if (valid !== exp_valid) begin
      failures++;
      $display("FAIL %s valid: valid=%b expected=%b", name, valid, exp_valid);
    end
`else
    if (exp_valid === 1'bx) $display("unreachable");
`endif
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic apply(input string name, input logic r, input logic e,
                       input logic [1:0] c, input logic [3:0] exp);
    reset = r;
    en    = e;
    in    = c;
    @(posedge clk);
    #1;
    check(name, exp, e & ~r);
  endtask

  initial begin
    logic [3:0] held;
    logic       r;
    logic       e;
    logic [1:0] c;
    logic [3:0] model;

    reset = 1'b1;
    en    = 1'b1;
    in    = 2'd3;

    // Reset priority over an active decode.
    add("reset0", 1'b1, 1'b1, 2'd3, 4'b0000);
    add("reset1", 1'b1, 1'b1, 2'd3, 4'b0000);
    // Disabled: every code yields zero.
    add("dis_in0", 1'b0, 1'b0, 2'd0, 4'b0000);
    add("dis_in1", 1'b0, 1'b0, 2'd1, 4'b0000);
    add("dis_in2", 1'b0, 1'b0, 2'd2, 4'b0000);
    add("dis_in3", 1'b0, 1'b0, 2'd3, 4'b0000);
    // Enabled sweep.
    add("en_in0", 1'b0, 1'b1, 2'd0, 4'b0001);
    add("en_in1", 1'b0, 1'b1, 2'd1, 4'b0010);
    add("en_in2", 1'b0, 1'b1, 2'd2, 4'b0100);
    add("en_in3", 1'b0, 1'b1, 2'd3, 4'b1000);

    @(negedge clk);
    foreach (vecs[i]) begin
      apply(vecs[i].name, vecs[i].reset, vecs[i].en, vecs[i].in, vecs[i].exp);
    end

    // Reset mid-stream clears, and the first edge after release reloads.
    apply("mid_pre", 1'b0, 1'b1, 2'd2, 4'b0100);
    apply("mid_rst", 1'b1, 1'b1, 2'd2, 4'b0000);
    apply("mid_post", 1'b0, 1'b1, 2'd2, 4'b0100);

    // en toggling: output follows with one cycle lag.
    apply("tog_1", 1'b0, 1'b1, 2'd1, 4'b0010);
    apply("tog_0", 1'b0, 1'b0, 2'd1, 4'b0000);
    apply("tog_1b", 1'b0, 1'b1, 2'd1, 4'b0010);

    // Between edges, input changes must not reach bcode.
    held = bcode;
    in   = 2'd3;
    en   = 1'b1;
    #3;
    check("hold_in", held, 1'b1);
    en = 1'b0;
    #3;
    check("hold_en", held, 1'b1);

    // Random run against a reference model.
    for (int k = 0; k < 1000; k++) begin
      r = ($urandom_range(0, 15) == 0);
      e = 1'($urandom_range(0, 1));
      c = 2'($urandom_range(0, 3));
      case ({r, e})
        2'b01:   model = 4'b0001 << c;
        default: model = 4'b0000;
      endcase
      apply("random", r, e, c, model);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
